mont_reduce_iter: RTL



---
 rtl/mont_reduce_iter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mont_reduce_iter.sv
// mont_reduce_iter: word-serial Montgomery reduction.
// Computes new_a = a * 2^(-RADIX*rounds) mod m.
// Each cycle retires one RADIX-bit digit, and a final cycle applies one
// conditional subtraction. The block uses valid/ready handshakes on both sides.
module mont_reduce_iter #(
  parameter int SIZE     = 256,
  parameter int RADIX    = 16,
  parameter int ROUNDS_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     a,
  input  logic [SIZE-1:0]     m,
  input  logic [RADIX-1:0]    m_prime,
  input  logic [ROUNDS_W-1:0] rounds,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     new_a,
  output logic                err,
  output logic                busy
);

  // The accumulator carries one extra bit because t < 2m.
  localparam int TW   = SIZE + 1;
  // The round sum must hold t + q*m before the shift, so no bits are lost.
  localparam int SUMW = SIZE + RADIX + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_SUB   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         t_q, t_d;
  logic [SIZE-1:0]       m_q, m_d;
  logic [RADIX-1:0]      mp_q, mp_d;
  logic [ROUNDS_W-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0]       new_a_q, new_a_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;

  logic                  in_ready_s;
  logic                  accept_s;
  logic [RADIX-1:0]      q_s;
  logic [TW-1:0]         t_round_s;
  logic [TW-1:0]         m_ext_s;
  logic                  t_ge_m_s;

  // Compute the datapath terms for the current round and for the final subtraction.
  always_comb begin
    m_ext_s   = {1'b0, m_q};
    // The digit multiplier is taken mod 2^RADIX by the width of q_s.
    q_s       = t_q[RADIX-1:0] * mp_q;
    // After the add, the low RADIX bits are zero by construction.
    // The shift therefore divides exactly.
    t_round_s = TW'((SUMW'(t_q) + SUMW'(q_s) * SUMW'(m_q)) >> RADIX);
    t_ge_m_s  = (t_q >= m_ext_s);
  end

  // Compute the handshake and the next state. A new request may be accepted
  // in DONE when the current result is consumed on the same edge.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    m_d         = m_q;
    mp_d        = mp_q;
    cnt_d       = cnt_q;
    new_a_d     = new_a_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE:  in_ready_s = 1'b1;
      ST_DONE:  in_ready_s = out_ready;
      default:  in_ready_s = 1'b0;
    endcase
    accept_s = in_valid & in_ready_s;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ROUND: begin
        t_d   = t_round_s;
        cnt_d = cnt_q - ROUNDS_W'(1);
        if (cnt_q == ROUNDS_W'(1)) begin
          state_d = ST_SUB;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_SUB: begin
        if (t_ge_m_s) begin
          new_a_d = SIZE'(t_q - m_ext_s);
        end else begin
          new_a_d = t_q[SIZE-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Loading an operand set overrides the state update above.
    // This lets the DONE hand-off go straight to ROUND or SUB without an idle cycle.
    if (accept_s) begin
      t_d   = {1'b0, a};
      m_d   = m;
      mp_d  = m_prime;
      cnt_d = rounds;
      err_d = ~m[0];
      if (rounds != '0) begin
        state_d = ST_ROUND;
      end else begin
        state_d = ST_SUB;
      end
    end else begin
      t_d = t_d;
    end
  end

  // Register all state. The synchronous active-low reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      m_q         <= '0;
      mp_q        <= '0;
      cnt_q       <= '0;
      new_a_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      m_q         <= m_d;
      mp_q        <= mp_d;
      cnt_q       <= cnt_d;
      new_a_q     <= new_a_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign new_a     = new_a_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
